line_stepper: RTL and testbench
===============================

# line_stepper

Parametrised Bresenham line stepper for the drawing datapath: it takes a start point and an end point and emits one unit step per handshake as a direction pair plus the updated position, until the end point is reached. It generalises the fixed 8-bit stepper in three ways: coordinate width is a parameter, the consumer can apply backpressure through a valid/ready step stream, and a chain mode draws polylines without reloading the start point. It sits between the shape command decoder and the pen/cursor driver.

## Interface
- W, 8: coordinate width in bits; coordinates are unsigned, 0..2^W-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request a new segment; sampled only when busy=0.
- chain  in  1  sampled with start; 1 = segment begins at current cur_x/cur_y and start_x/start_y are ignored.
- abort  in  1  ends the current segment immediately.
- start_x, start_y  in  W  segment start point.
- end_x, end_y  in  W  segment end point.
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
- step_valid  out  1  a step is presented on dirx/diry.
- step_ready  in  1  the consumer accepts the presented step.
- dirx, diry  out  2  step direction: 2'b00 no move, 2'b01 +1, 2'b10 -1; 2'b11 is never driven.
- cur_x, cur_y  out  W  current pen position; updates on each accepted step.
- done  out  1  one-cycle pulse at the end of a segment.

## Operation
- States: IDLE, STEP, DONE.
- **IDLE**
  - start=1 loads x0/y0: start_x/start_y if chain=0, otherwise cur_x/cur_y.
  - Also loads ex, ey, dx=|ex-x0|, dy=|ey-y0|, sx/sy = sign of the difference (0 when equal), and err=dx-dy.
  - If (x0,y0)==(ex,ey), next state is DONE; otherwise next state is STEP.
  - cur_x/cur_y take x0/y0 on the accept edge.
- **STEP**
  - step_valid=1. With e2=2*err:
    - mx = (e2 > -dy): dirx = sx when mx, else 00.
    - my = (e2 < dx): diry = sy when my, else 00.
  - On step_valid & step_ready:
    - when mx: cur_x += sx and err -= dy.
    - when my: cur_y += sy and err += dx (both adjustments apply in the same cycle).
    - If the updated position equals (ex,ey), next state is DONE.
  - With step_ready=0, dirx/diry/cur_x/cur_y and all internal state hold.
- **DONE**: done=1 for exactly one cycle, then IDLE; cur_x/cur_y keep the end point.
- **abort**:
  - In STEP, abort goes to DONE next cycle. Abort wins over a simultaneous handshake, and that step is not applied.
  - In IDLE or DONE, abort is ignored.
- **Width rules**:
  - dx, dy are W bits unsigned.
  - err and e2 are (W+2)-bit two's complement; no overflow for any W-bit endpoints.
  - cur never wraps, because steps stop at the end point.
- Steps per segment = max(dx,dy); x moves = dx, y moves = dy.
- start while busy=1 is ignored and is not queued.

## Timing
- Reset (rst=0 at an edge) forces: IDLE, busy=0, step_valid=0, done=0, dirx=diry=00, cur_x=cur_y=0, err=0.
- Reset mid-segment abandons the segment with no done pulse.
- Start accepted at edge N: busy=1 and step_valid=1 from cycle N+1.
  - Zero-length segment: done=1 in cycle N+1, and busy stays 0.
- Each step needs one cycle when step_ready is held at 1. A segment of n steps has done in cycle N+1+n and busy high for cycles N+1..N+n.
- The earliest new start is in the cycle after done, which gives a two-cycle bubble between chained segments.
- All outputs are registered or decoded from registered state; there is no combinational path from step_ready to step_valid.

## Structure
- Shared package line_pkg: localparams DIR_NONE=2'b00, DIR_POS=2'b01, DIR_NEG=2'b10, and the state encoding S_IDLE/S_STEP/S_DONE.
- Single module, with no sub-module; the absolute-difference and sign logic is inline.

## Test plan
- **Reset/idle:** hold rst=0 for 2 cycles, then release -> cur=(0,0), all strobes 0, busy=0.
- **Negative octant:** (30,30)->(24,21), W=8, ready=1 -> exactly 9 steps; 6 with dirx=10, 9 with diry=10; final cur=(24,21); done in cycle 10 after accept.
- **Long diagonal plus chain:** (20,25)->(83,87) -> 63 steps, 63 x moves at +1, 62 y moves at +1. After done, start with chain=1 and end (83,10) -> 77 steps, all dirx=00, diry=10.
- **Backpressure:** the same segment with step_ready toggling randomly -> identical step sequence; outputs stable while ready=0.
- **Degenerate cases:**
  - start==end -> no step_valid; done one cycle after accept.
  - Horizontal (0,5)->(255,5) -> 255 steps with diry=00.
- **Abort and reset mid-segment:**
  - abort with ready=1 at step 3 -> done next cycle, cur at the 2-step position.
  - rst=0 mid-segment -> IDLE, cur=(0,0), no done.

Source files
------------

// File: rtl/line_pkg.sv
// Shared encodings for the line stepper: step direction codes and FSM states.
// Combinational helpers only; no latency, no flow control.
package line_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Direction code from "end is above" / "end is below" flags; 00 when equal.
  function automatic logic [1:0] dir_of(input logic gt, input logic lt);
    return gt ? DIR_POS : (lt ? DIR_NEG : DIR_NONE);
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham stepper: start accepted at edge N, one step per cycle from N+1 while step_ready=1, done after the last step.
// step_ready=0 freezes position, error term and presented direction; step_valid never depends on step_ready.
module line_stepper
  import line_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         chain,
  input  logic         abort,
  input  logic [W-1:0] start_x,
  input  logic [W-1:0] start_y,
  input  logic [W-1:0] end_x,
  input  logic [W-1:0] end_y,
  output logic         busy,
  output logic         step_valid,
  input  logic         step_ready,
  output logic [1:0]   dirx,
  output logic [1:0]   diry,
  output logic [W-1:0] cur_x,
  output logic [W-1:0] cur_y,
  output logic         done
);

  localparam int EW = W + 2;

  state_t state, state_nxt;

  logic [W-1:0]         ex, ey, dx, dy;
  logic [1:0]           sx, sy;
  logic signed [EW-1:0] err;

  logic [W-1:0]         x0, y0, ldx, ldy, nx, ny;
  logic [1:0]           lsx, lsy;
  logic signed [EW-1:0] e2, dx_s, dy_s, err_nxt;
  logic                 mx, my, fire;

  // Segment setup: origin is either the requested start or the current pen.
  always_comb begin
    x0  = chain ? cur_x : start_x;
    y0  = chain ? cur_y : start_y;
    ldx = (end_x >= x0) ? end_x - x0 : x0 - end_x;
    ldy = (end_y >= y0) ? end_y - y0 : y0 - end_y;
    lsx = dir_of(end_x > x0, end_x < x0);
    lsy = dir_of(end_y > y0, end_y < y0);
  end

  assign dx_s = $signed({2'b00, dx});
  assign dy_s = $signed({2'b00, dy});
  assign e2   = err <<< 1;
  assign mx   = e2 > -dy_s;
  assign my   = e2 < dx_s;
  assign fire = (state == S_STEP) && step_ready;

  always_comb begin
    nx = cur_x;
    ny = cur_y;
    if (mx && sx == DIR_POS) nx = cur_x + W'(1);
    if (mx && sx == DIR_NEG) nx = cur_x - W'(1);
    if (my && sy == DIR_POS) ny = cur_y + W'(1);
    if (my && sy == DIR_NEG) ny = cur_y - W'(1);
    err_nxt = err - (mx ? dy_s : '0) + (my ? dx_s : '0);
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    step_valid = 1'b0;
    done       = 1'b0;
    dirx       = DIR_NONE;
    diry       = DIR_NONE;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (x0 == end_x && y0 == end_y) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        busy       = 1'b1;
        step_valid = 1'b1;
        dirx       = mx ? sx : DIR_NONE;
        diry       = my ? sy : DIR_NONE;
        // Abort takes priority; the step presented this cycle is dropped.
        if (abort) state_nxt = S_DONE;
        else if (fire && nx == ex && ny == ey) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cur_x <= '0;
      cur_y <= '0;
      ex    <= '0;
      ey    <= '0;
      dx    <= '0;
      dy    <= '0;
      sx    <= DIR_NONE;
      sy    <= DIR_NONE;
      err   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_x <= x0;
            cur_y <= y0;
            ex    <= end_x;
            ey    <= end_y;
            dx    <= ldx;
            dy    <= ldy;
            sx    <= lsx;
            sy    <= lsy;
            err   <= $signed({2'b00, ldx}) - $signed({2'b00, ldy});
          end
        end
        S_STEP: begin
          if (fire && !abort) begin
            cur_x <= nx;
            cur_y <= ny;
            err   <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_stepper.sv
// Directed bench for line_stepper with a plain-integer line model and a per-cycle step scoreboard.
module tb_line_stepper;

  logic       clk = 1'b0;
  logic       rst, start, chain, abort, step_ready;
  logic [7:0] start_x, start_y, end_x, end_y;
  logic       busy, step_valid, done;
  logic [1:0] dirx, diry;
  logic [7:0] cur_x, cur_y;

  int checks = 0;
  int errors = 0;

  // Expected step list for the current segment: direction and pen position before each step.
  logic [1:0] exp_dirx [0:599];
  logic [1:0] exp_diry [0:599];
  int         exp_px   [0:599];
  int         exp_py   [0:599];
  int exp_n, exp_fx, exp_fy, m_nx, m_ny;
  int eidx, dut_nx, dut_ny;
  int m_x = 0, m_y = 0;

  line_stepper #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .chain(chain), .abort(abort),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
    .busy(busy), .step_valid(step_valid), .step_ready(step_ready),
    .dirx(dirx), .diry(diry), .cur_x(cur_x), .cur_y(cur_y), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [1:0] enc(input int s);
    return (s > 0) ? 2'b01 : ((s < 0) ? 2'b10 : 2'b00);
  endfunction

  // Textbook integer Bresenham walk from (x0,y0) to (x1,y1).
  task automatic model_segment(input int x0, input int y0, input int x1, input int y1);
    int x, y, adx, ady, gx, gy, e, e2;
    x = x0; y = y0;
    adx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ady = (y1 > y0) ? y1 - y0 : y0 - y1;
    gx = (x1 > x0) ? 1 : ((x1 < x0) ? -1 : 0);
    gy = (y1 > y0) ? 1 : ((y1 < y0) ? -1 : 0);
    e = adx - ady;
    exp_n = 0; m_nx = 0; m_ny = 0;
    while ((x != x1 || y != y1) && exp_n < 600) begin
      e2 = 2 * e;
      exp_px[exp_n] = x; exp_py[exp_n] = y;
      exp_dirx[exp_n] = 2'b00; exp_diry[exp_n] = 2'b00;
      if (e2 > -ady) begin exp_dirx[exp_n] = enc(gx); x += gx; e -= ady; m_nx++; end
      if (e2 < adx)  begin exp_diry[exp_n] = enc(gy); y += gy; e += adx; m_ny++; end
      exp_n++;
    end
    exp_fx = x; exp_fy = y;
    eidx = 0; dut_nx = 0; dut_ny = 0;
  endtask

  // Scoreboard: every presented step must match the model's next step, held until accepted.
  always @(negedge clk) begin
    if (step_valid === 1'b1) begin
      if (eidx >= exp_n) begin
        check("extra step_valid", 64'(step_valid), 64'd0);
      end else begin
        check($sformatf("dirx step %0d", eidx), 64'(dirx), 64'(exp_dirx[eidx]));
        check($sformatf("diry step %0d", eidx), 64'(diry), 64'(exp_diry[eidx]));
        check($sformatf("cur_x step %0d", eidx), 64'(cur_x), 64'(exp_px[eidx]));
        check($sformatf("cur_y step %0d", eidx), 64'(cur_y), 64'(exp_py[eidx]));
        if (step_ready && !abort) begin
          if (dirx != 2'b00) dut_nx++;
          if (diry != 2'b00) dut_ny++;
          eidx++;
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the edge following done.
  task automatic run_seg(input string nm, input int x0, input int y0, input int x1, input int y1,
                         input bit ch, input bit rnd, input int abort_at, input int exp_cyc);
    int k, got, fx, fy;
    model_segment(ch ? m_x : x0, ch ? m_y : y0, x1, y1);
    start_x = 8'(x0); start_y = 8'(y0); end_x = 8'(x1); end_y = 8'(y1);
    chain = ch; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; chain = 1'b0;
    k = 1; got = -1;
    while (k <= 3000 && got < 0) begin
      step_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      abort = (k == abort_at);
      @(negedge clk);
      if (done) begin
        got = k;
        check({nm, " busy at done"}, 64'(busy), 64'd0);
      end else begin
        check({nm, " busy"}, 64'(busy), 64'(exp_n > 0));
      end
      @(posedge clk); #1;
      k++;
    end
    abort = 1'b0; step_ready = 1'b1;
    check({nm, " done seen"}, 64'(got > 0), 64'd1);
    if (exp_cyc >= 0) check({nm, " done cycle"}, 64'(got), 64'(exp_cyc));
    fx = (eidx < exp_n) ? exp_px[eidx] : exp_fx;
    fy = (eidx < exp_n) ? exp_py[eidx] : exp_fy;
    check({nm, " final cur_x"}, 64'(cur_x), 64'(fx));
    check({nm, " final cur_y"}, 64'(cur_y), 64'(fy));
    check({nm, " done is one pulse"}, 64'(done), 64'd0);
    m_x = fx; m_y = fy;
  endtask

  initial begin
    exp_n = 0; eidx = 0;
    rst = 1'b0; start = 1'b0; chain = 1'b0; abort = 1'b0; step_ready = 1'b1;
    start_x = '0; start_y = '0; end_x = '0; end_y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset cur_x", 64'(cur_x), 64'd0);
    check("reset cur_y", 64'(cur_y), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset step_valid", 64'(step_valid), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dirx", 64'(dirx), 64'd0);
    check("reset diry", 64'(diry), 64'd0);
    @(posedge clk); #1;

    run_seg("neg_octant", 30, 30, 24, 21, 1'b0, 1'b0, 0, 10);
    check("neg_octant model steps", 64'(exp_n), 64'd9);
    check("neg_octant model x moves", 64'(m_nx), 64'd6);
    check("neg_octant dut x moves", 64'(dut_nx), 64'd6);
    check("neg_octant dut y moves", 64'(dut_ny), 64'd9);
    check("neg_octant step1 dirx", 64'(exp_dirx[0]), 64'd2);
    check("neg_octant end x", 64'(cur_x), 64'd24);
    check("neg_octant end y", 64'(cur_y), 64'd21);

    run_seg("diag", 20, 25, 83, 87, 1'b0, 1'b0, 0, 64);
    check("diag model steps", 64'(exp_n), 64'd63);
    check("diag dut x moves", 64'(dut_nx), 64'd63);
    check("diag dut y moves", 64'(dut_ny), 64'd62);

    run_seg("chain", 200, 200, 83, 10, 1'b1, 1'b0, 0, 78);
    check("chain model steps", 64'(exp_n), 64'd77);
    check("chain dut x moves", 64'(dut_nx), 64'd0);
    check("chain dut y moves", 64'(dut_ny), 64'd77);
    check("chain end y", 64'(cur_y), 64'd10);

    run_seg("backpressure", 20, 25, 83, 87, 1'b0, 1'b1, 0, -1);
    check("backpressure dut x moves", 64'(dut_nx), 64'd63);
    check("backpressure dut y moves", 64'(dut_ny), 64'd62);

    run_seg("zero_len", 7, 7, 7, 7, 1'b0, 1'b0, 0, 1);
    check("zero_len model steps", 64'(exp_n), 64'd0);

    run_seg("horizontal", 0, 5, 255, 5, 1'b0, 1'b0, 0, 256);
    check("horizontal dut x moves", 64'(dut_nx), 64'd255);
    check("horizontal dut y moves", 64'(dut_ny), 64'd0);
    check("horizontal end x", 64'(cur_x), 64'd255);

    run_seg("abort", 30, 30, 24, 21, 1'b0, 1'b0, 3, 4);
    check("abort accepted steps", 64'(eidx), 64'd2);
    check("abort cur_x", 64'(cur_x), 64'd29);
    check("abort cur_y", 64'(cur_y), 64'd28);

    // Reset in the middle of a segment: no done, pen back at the origin.
    model_segment(0, 0, 100, 50);
    start_x = 8'd0; start_y = 8'd0; end_x = 8'd100; end_y = 8'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; exp_n = 0; eidx = 0;
    check("midreset step_valid", 64'(step_valid), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset cur_x", 64'(cur_x), 64'd0);
    check("midreset cur_y", 64'(cur_y), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("midreset no done", 64'(done), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
